// File: rtl/dcache_flush_arbiter_if.sv
// Handshake bundle between the flush requesters, the flush arbiter and the DCache flush port.
// The master modport is the arbiter side; the slave modport is the requester/DCache side.
interface dcache_flush_arbiter_if #(
    parameter int unsigned NR_REQ = 4,
    parameter int unsigned CNT_W  = 10
);
    logic [NR_REQ-1:0] req_i;
    logic [NR_REQ-1:0] gnt_o;
    logic [NR_REQ-1:0] done_o;
    logic              flush_dcache_o;
    logic              flush_dcache_ack_i;
    logic [CNT_W-1:0]  timeout_limit_i;
    logic              busy_o;
    logic              timeout_o;

    modport master (
        input  req_i,
        input  flush_dcache_ack_i,
        input  timeout_limit_i,
        output gnt_o,
        output done_o,
        output flush_dcache_o,
        output busy_o,
        output timeout_o
    );

    modport slave (
        output req_i,
        output flush_dcache_ack_i,
        output timeout_limit_i,
        input  gnt_o,
        input  done_o,
        input  flush_dcache_o,
        input  busy_o,
        input  timeout_o
    );
endinterface

// File: rtl/dcache_flush_arbiter.sv
// Round-robin arbiter sharing the single DCache flush port, with an ack watchdog.
// Define FLUSH_ARB_COALESCE_EN to serve every pending requester with one flush.
module dcache_flush_arbiter #(
    parameter int unsigned NR_REQ = 4,
    parameter int unsigned CNT_W  = 10
) (
    input logic                    clk_i,
    input logic                    rst_i,
    dcache_flush_arbiter_if.master bus
);
    localparam int unsigned PtrW = (NR_REQ > 1) ? $clog2(NR_REQ) : 1;

    typedef enum logic [1:0] {StIdle, StIssue, StWaitAck, StDone} state_e;

    state_e            state_q, state_d;
    logic [PtrW-1:0]   ptr_q, ptr_d;
    logic [NR_REQ-1:0] mask_q, mask_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              flush_q, flush_d;
    logic              timeout_q, timeout_d;

    logic [NR_REQ-1:0] grant_sel;
    logic [PtrW-1:0]   ptr_nxt;
    logic [CNT_W-1:0]  cnt_inc;
    logic              ptr_found;

`ifdef FLUSH_ARB_COALESCE_EN
    assign grant_sel = bus.req_i;
`else
    logic win_found;

    // First set bit at or after ptr_q, then wrap to the low end.
    always_comb begin
        grant_sel = '0;
        win_found = 1'b0;
        for (int i = 0; i < NR_REQ; i++) begin
            if (!win_found && bus.req_i[i] && (i >= int'(ptr_q))) begin
                grant_sel[i] = 1'b1;
                win_found    = 1'b1;
            end
        end
        for (int i = 0; i < NR_REQ; i++) begin
            if (!win_found && bus.req_i[i]) begin
                grant_sel[i] = 1'b1;
                win_found    = 1'b1;
            end
        end
    end
`endif

    // Pointer moves just past the lowest-index requester served by this flush.
    always_comb begin
        ptr_nxt   = ptr_q;
        ptr_found = 1'b0;
        for (int i = 0; i < NR_REQ; i++) begin
            if (!ptr_found && mask_q[i]) begin
                ptr_found = 1'b1;
                ptr_nxt   = (i == NR_REQ - 1) ? '0 : PtrW'(i + 1);
            end
        end
    end

    assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        mask_d    = mask_q;
        cnt_d     = cnt_q;
        flush_d   = 1'b0;
        timeout_d = 1'b0;
        case (state_q)
            StIdle: begin
                if (|bus.req_i) begin
                    mask_d  = grant_sel;
                    flush_d = 1'b1;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                cnt_d = '0;
                if (bus.flush_dcache_ack_i) begin
                    state_d = StDone;
                end else begin
                    flush_d = 1'b1;
                    state_d = StWaitAck;
                end
            end
            StWaitAck: begin
                cnt_d = cnt_inc;
                if (bus.flush_dcache_ack_i) begin
                    state_d = StDone;
                end else if ((bus.timeout_limit_i != '0) && (cnt_inc == bus.timeout_limit_i)) begin
                    timeout_d = 1'b1;
                    state_d   = StDone;
                end else begin
                    flush_d = 1'b1;
                end
            end
            StDone: begin
                ptr_d   = ptr_nxt;
                mask_d  = '0;
                state_d = StIdle;
            end
            default: begin
                mask_d  = '0;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            ptr_q     <= '0;
            mask_q    <= '0;
            cnt_q     <= '0;
            flush_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            mask_q    <= mask_d;
            cnt_q     <= cnt_d;
            flush_q   <= flush_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.gnt_o          = mask_q;
    assign bus.done_o         = (state_q == StDone) ? mask_q : '0;
    assign bus.flush_dcache_o = flush_q;
    assign bus.busy_o         = (state_q != StIdle);
    assign bus.timeout_o      = timeout_q;

endmodule

// File: tb/tb_dcache_flush_arbiter.sv
// Directed bench for dcache_flush_arbiter: a per-cycle vector table plus hand-written
// sequences for watchdog, dropped/late requests, reset mid-flush and round-robin fairness.
module tb_dcache_flush_arbiter;
    logic clk_i = 1'b0;
    logic rst_i = 1'b1;

    int checks = 0;
    int errors = 0;

`ifdef FLUSH_ARB_COALESCE_EN
    localparam bit Coal = 1'b1;
`else
    localparam bit Coal = 1'b0;
`endif

    dcache_flush_arbiter_if #(.NR_REQ(4), .CNT_W(10)) bus ();

    dcache_flush_arbiter #(.NR_REQ(4), .CNT_W(10)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    always #5 clk_i = ~clk_i;

    // Packed expected outputs: {gnt[3:0], done[3:0], flush, busy, timeout}.
    function automatic logic [10:0] outs(input logic [3:0] gnt, input logic [3:0] done,
                                         input logic flush, input logic busy, input logic tmo);
        return {gnt, done, flush, busy, tmo};
    endfunction

    typedef struct packed {
        logic [3:0]  req;
        logic        ack;
        logic [10:0] exp;
    } vec_t;

    vec_t vecs [16];

    task automatic chk(input string name, input logic [10:0] exp);
        logic [10:0] act;
        act = {bus.gnt_o, bus.done_o, bus.flush_dcache_o, bus.busy_o, bus.timeout_o};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got gnt=%b done=%b flush=%b busy=%b tmo=%b, expected gnt=%b done=%b flush=%b busy=%b tmo=%b",
                     name, act[10:7], act[6:3], act[2], act[1], act[0],
                     exp[10:7], exp[6:3], exp[2], exp[1], exp[0]);
        end
    endtask

    // Inputs are changed at negedge; one step crosses exactly one active edge.
    task automatic step();
        @(negedge clk_i);
    endtask

    logic [3:0] g10;
    logic [3:0] gexp;

    initial begin
        g10 = Coal ? 4'b0101 : 4'b0100;
        vecs[0]  = '{4'b0000, 1'b1, outs(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0)};
        vecs[1]  = '{4'b0000, 1'b0, outs(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0)};
        vecs[2]  = '{4'b0010, 1'b0, outs(4'b0010, 4'b0000, 1'b1, 1'b1, 1'b0)};
        vecs[3]  = '{4'b0010, 1'b0, outs(4'b0010, 4'b0000, 1'b1, 1'b1, 1'b0)};
        vecs[4]  = '{4'b0010, 1'b0, outs(4'b0010, 4'b0000, 1'b1, 1'b1, 1'b0)};
        vecs[5]  = '{4'b0010, 1'b0, outs(4'b0010, 4'b0000, 1'b1, 1'b1, 1'b0)};
        vecs[6]  = '{4'b0010, 1'b0, outs(4'b0010, 4'b0000, 1'b1, 1'b1, 1'b0)};
        vecs[7]  = '{4'b0010, 1'b0, outs(4'b0010, 4'b0000, 1'b1, 1'b1, 1'b0)};
        vecs[8]  = '{4'b0010, 1'b1, outs(4'b0010, 4'b0010, 1'b0, 1'b1, 1'b0)};
        vecs[9]  = '{4'b0000, 1'b0, outs(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0)};
        vecs[10] = '{4'b0101, 1'b0, outs(g10,     4'b0000, 1'b1, 1'b1, 1'b0)};
        vecs[11] = '{4'b0101, 1'b1, outs(g10,     g10,     1'b0, 1'b1, 1'b0)};
        vecs[12] = '{4'b0001, 1'b1, outs(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0)};
        vecs[13] = '{4'b0001, 1'b0, outs(4'b0001, 4'b0000, 1'b1, 1'b1, 1'b0)};
        vecs[14] = '{4'b0001, 1'b1, outs(4'b0001, 4'b0001, 1'b0, 1'b1, 1'b0)};
        vecs[15] = '{4'b0000, 1'b0, outs(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0)};

        bus.req_i              = '0;
        bus.flush_dcache_ack_i = 1'b0;
        bus.timeout_limit_i    = '0;

        // Reset state, then after release.
        step();
        step();
        chk("reset_held", outs(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0));
        rst_i = 1'b0;
        step();
        chk("reset_released", outs(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0));

        // Stray acks, single request with late ack, ack-in-ISSUE, pointer wrap.
        for (int i = 0; i < 16; i++) begin
            bus.req_i              = vecs[i].req;
            bus.flush_dcache_ack_i = vecs[i].ack;
            step();
            chk($sformatf("vec%0d", i), vecs[i].exp);
        end

        // Pointer is 1 here: 1011 serves only requester 1, or all three when coalescing.
        gexp = Coal ? 4'b1011 : 4'b0010;
        bus.req_i = 4'b1011;
        step();
        chk("coal_issue", outs(gexp, 4'b0000, 1'b1, 1'b1, 1'b0));
        bus.flush_dcache_ack_i = 1'b1;
        step();
        chk("coal_done", outs(gexp, gexp, 1'b0, 1'b1, 1'b0));
        bus.flush_dcache_ack_i = 1'b0;
        bus.req_i = 4'b0000;
        step();
        chk("coal_idle", outs(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0));

        // Watchdog expiry with limit 8 and no ack.
        bus.timeout_limit_i = 10'd8;
        bus.req_i = 4'b0001;
        step();
        chk("wd_issue", outs(4'b0001, 4'b0000, 1'b1, 1'b1, 1'b0));
        step();
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("wd_wait%0d", k), outs(4'b0001, 4'b0000, 1'b1, 1'b1, 1'b0));
            step();
        end
        chk("wd_expire", outs(4'b0001, 4'b0001, 1'b0, 1'b1, 1'b1));
        bus.req_i = 4'b0000;
        step();
        chk("wd_after", outs(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0));

        // Ack in the same cycle as expiry: ack wins, no timeout pulse.
        bus.req_i = 4'b0001;
        step();
        step();
        for (int k = 0; k < 7; k++) step();
        bus.flush_dcache_ack_i = 1'b1;
        step();
        chk("wd_ack_tie", outs(4'b0001, 4'b0001, 1'b0, 1'b1, 1'b0));
        bus.flush_dcache_ack_i = 1'b0;
        bus.req_i = 4'b0000;
        bus.timeout_limit_i = '0;
        step();
        chk("wd_tie_after", outs(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0));

        // Requester drops mid-WAIT_ACK, another rises and must wait for the next flush.
        bus.req_i = 4'b0100;
        step();
        chk("drop_issue", outs(4'b0100, 4'b0000, 1'b1, 1'b1, 1'b0));
        step();
        bus.req_i = 4'b1000;
        step();
        step();
        bus.flush_dcache_ack_i = 1'b1;
        step();
        chk("drop_done", outs(4'b0100, 4'b0100, 1'b0, 1'b1, 1'b0));
        bus.flush_dcache_ack_i = 1'b0;
        step();
        chk("late_idle", outs(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0));
        step();
        chk("late_issue", outs(4'b1000, 4'b0000, 1'b1, 1'b1, 1'b0));
        bus.flush_dcache_ack_i = 1'b1;
        step();
        chk("late_done", outs(4'b1000, 4'b1000, 1'b0, 1'b1, 1'b0));
        bus.flush_dcache_ack_i = 1'b0;
        bus.req_i = 4'b0000;
        step();

        // Reset mid-flush clears outputs at once; first grant afterwards goes to requester 0.
        bus.req_i = 4'b0010;
        step();
        step();
        chk("rst_pre", outs(4'b0010, 4'b0000, 1'b1, 1'b1, 1'b0));
        rst_i = 1'b1;
        #1;
        chk("rst_async", outs(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0));
        bus.req_i = 4'b1111;
        step();
        rst_i = 1'b0;
        step();

        // Fairness with all requests held and acks in ISSUE.
        for (int i = 0; i < 5; i++) begin
            gexp = Coal ? 4'b1111 : 4'(1 << (i % 4));
            chk($sformatf("rr_gnt%0d", i), outs(gexp, 4'b0000, 1'b1, 1'b1, 1'b0));
            bus.flush_dcache_ack_i = 1'b1;
            step();
            chk($sformatf("rr_done%0d", i), outs(gexp, gexp, 1'b0, 1'b1, 1'b0));
            bus.flush_dcache_ack_i = 1'b0;
            step();
            chk($sformatf("rr_idle%0d", i), outs(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0));
            step();
        end
        bus.flush_dcache_ack_i = 1'b1;
        bus.req_i = 4'b0000;
        step();
        bus.flush_dcache_ack_i = 1'b0;
        step();
        chk("final_idle", outs(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
